score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Writer side of the two-player score display path.
- Takes ball-miss events from the game logic and owns the score_l/score_r registers that the score renderer reads.
- Sequences a match through idle, serve delay, play, point pause and game over, and issues one-cycle serve pulses to the ball logic.
- Sits in the pixel clock domain between the ball/paddle logic and the score renderer.

Parameters:
- WIN_SCORE, 9, score that ends the match; legal range 1-9 (renderer shows single digits only).
- SERVE_FRAMES, 60, frames to wait in SERVE before the serve pulse.
- POINT_FRAMES, 30, frames to pause in POINT after a score.
- OVER_FRAMES, 180, frames to hold GAME_OVER before auto-restart (used only with AUTO_RESTART_EN).

Ports:
- clk_pix  input  1  pixel clock.
- rst_pix_n  input  1  synchronous active-low reset.
- frame  input  1  one-cycle pulse at start of each frame.
- start  input  1  one-cycle start request (debounced button).
- miss_l  input  1  one-cycle pulse: ball left the left edge; right player scores.
- miss_r  input  1  one-cycle pulse: ball left the right edge; left player scores.
- score_l  output  4  left player score, 0..WIN_SCORE.
- score_r  output  4  right player score, 0..WIN_SCORE.
- serve  output  1  one-cycle pulse: launch ball from centre.
- serve_dir  output  1  ball direction for serve; 0 = toward left, 1 = toward right.
- playing  output  1  high while in PLAY.
- game_over  output  1  high while in GAME_OVER.
- winner  output  1  valid while game_over; 0 = left, 1 = right.

Behaviour:
- All outputs are registered.
- Reset, sampled on posedge clk_pix with rst_pix_n low, applies the following. Reset mid-operation aborts any state immediately.
  - State goes to IDLE.
  - score_l = score_r = 0.
  - serve = 0, serve_dir = 1.
  - playing = game_over = winner = 0.
  - Frame timer is cleared.
- States:
  - IDLE: scores hold 0. On start, go to SERVE, load the timer with SERVE_FRAMES and set serve_dir = 1.
  - SERVE: timer decrements on each frame pulse. On the cycle the timer reaches 0, go to PLAY and assert serve for exactly one cycle, together with the current serve_dir.
  - PLAY: playing = 1. miss_r increments score_l and sets serve_dir = 1 (toward the conceding right player). miss_l increments score_r and sets serve_dir = 0. The score register updates one cycle after the miss pulse. After a score:
    - if the new score equals WIN_SCORE, go to GAME_OVER and set winner;
    - otherwise go to POINT and load POINT_FRAMES.
  - POINT: count down frames, then go to SERVE and load SERVE_FRAMES.
  - GAME_OVER: game_over = 1; scores frozen. start clears both scores and goes to SERVE with serve_dir = 1.
- Boundary conditions:
  - miss_l and miss_r in the same cycle: both are ignored, no score change, and the block stays in PLAY.
  - miss pulses outside PLAY are ignored.
  - start outside IDLE and GAME_OVER is ignored.
  - frame and a state transition in the same cycle: the newly loaded timer value is not decremented that cycle.
  - A timer load of 0 means the block leaves the state on the next clock cycle without waiting for a frame.
  - Scores never exceed WIN_SCORE and never wrap.
- Frame timer width is $clog2(max(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES)+1).

Optional Feature:
- Macro: SCORE_KEEPER_AUTO_RESTART_EN.
- Defined: entering GAME_OVER loads OVER_FRAMES. When it expires, both scores are cleared and the block returns to IDLE. start during GAME_OVER still restarts immediately.
- Not defined: GAME_OVER holds until start or reset, and OVER_FRAMES is unused.

Decomposition:
- Shared package pong_pkg holds:
  - SCORE_W = 4;
  - MAX_DIGIT = 9;
  - the enum type game_state_t {IDLE, SERVE, PLAY, POINT, GAME_OVER};
  - the serve direction constants DIR_LEFT = 0 and DIR_RIGHT = 1.
- One sub-module, frame_timer, handles the countdown:
  - ports: load, load value, frame, done;
  - parameterised width;
  - synchronous active-low reset on the same clock and reset.

Test Plan:
- Reset then start with SERVE_FRAMES = 3 -> serve pulses exactly once, 3 frame pulses later, with serve_dir = 1; playing = 1 the following cycle.
- In PLAY, pulse miss_r -> next cycle score_l = 1, score_r = 0, state POINT. After POINT_FRAMES + SERVE_FRAMES frames, serve pulses with serve_dir = 1.
- With WIN_SCORE = 3, apply three miss_l events across rallies -> score_r = 3, game_over = 1, winner = 1. Further miss_l and miss_r leave scores at 0/3.
- miss_l and miss_r in the same cycle during PLAY -> scores unchanged, playing stays 1. A miss_r pulse during SERVE -> ignored.
- Drive rst_pix_n low for one cycle mid-POINT with scores 2/1 -> scores return to 0/0, state IDLE, no serve pulse until start.
- With SCORE_KEEPER_AUTO_RESTART_EN and OVER_FRAMES = 2 -> two frames after game_over rises, scores read 0/0 and state is IDLE. Without the macro, game_over stays high for 10 or more frames.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score path.
package pong_pkg;

    localparam int SCORE_W   = 4;
    localparam int MAX_DIGIT = 9;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        GAME_OVER
    } game_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Saturating increment so a score can never pass the match limit.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic [SCORE_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/score_keeper_frame_timer.sv
// Frame-granular countdown; a load always wins over a coincident frame pulse.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk_pix,
    input  logic         rst_pix_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (frame && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/score_keeper.sv
// Match sequencer and score registers for the two-player display.
// Optional SCORE_KEEPER_AUTO_RESTART_EN: GAME_OVER times out back to IDLE.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int OVER_FRAMES  = 180
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic               frame,
    input  logic               start,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               serve,
    output logic               serve_dir,
    output logic               playing,
    output logic               game_over,
    output logic               winner
);

    localparam int TW = $clog2(max3(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES) + 1);
    localparam logic [TW-1:0]      T_SERVE = TW'(SERVE_FRAMES);
    localparam logic [TW-1:0]      T_POINT = TW'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

    game_state_t        state, state_n;
    logic [SCORE_W-1:0] score_l_n, score_r_n;
    logic               serve_n, serve_dir_n, winner_n;
    logic               tmr_load, tmr_done;
    logic [TW-1:0]      tmr_val;

    frame_timer #(.W(TW)) u_timer (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .frame     (frame),
        .done      (tmr_done)
    );

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state     <= IDLE;
            score_l   <= '0;
            score_r   <= '0;
            serve     <= 1'b0;
            serve_dir <= DIR_RIGHT;
            playing   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            state     <= state_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            serve     <= serve_n;
            serve_dir <= serve_dir_n;
            playing   <= (state_n == PLAY);
            game_over <= (state_n == GAME_OVER);
            winner    <= winner_n;
        end
    end

    always_comb begin
        state_n     = state;
        score_l_n   = score_l;
        score_r_n   = score_r;
        serve_n     = 1'b0;
        serve_dir_n = serve_dir;
        winner_n    = winner;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state)
            IDLE: begin
                score_l_n = '0;
                score_r_n = '0;
                if (start) begin
                    state_n     = SERVE;
                    tmr_load    = 1'b1;
                    tmr_val     = T_SERVE;
                    serve_dir_n = DIR_RIGHT;
                end
            end
            SERVE: begin
                if (tmr_done) begin
                    state_n = PLAY;
                    serve_n = 1'b1;
                end
            end
            PLAY: begin
                // A simultaneous miss on both edges is treated as noise.
                if (miss_r != miss_l) begin
                    if (miss_r) begin
                        score_l_n   = sat_inc(score_l, WIN);
                        serve_dir_n = DIR_RIGHT;
                    end else begin
                        score_r_n   = sat_inc(score_r, WIN);
                        serve_dir_n = DIR_LEFT;
                    end
                    if (score_l_n == WIN || score_r_n == WIN) begin
                        state_n  = GAME_OVER;
                        winner_n = miss_l;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
                        tmr_load = 1'b1;
                        tmr_val  = TW'(OVER_FRAMES);
`endif
                    end else begin
                        state_n  = POINT;
                        tmr_load = 1'b1;
                        tmr_val  = T_POINT;
                    end
                end
            end
            POINT: begin
                if (tmr_done) begin
                    state_n  = SERVE;
                    tmr_load = 1'b1;
                    tmr_val  = T_SERVE;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    state_n     = SERVE;
                    score_l_n   = '0;
                    score_r_n   = '0;
                    tmr_load    = 1'b1;
                    tmr_val     = T_SERVE;
                    serve_dir_n = DIR_RIGHT;
                end
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
                else if (tmr_done) begin
                    state_n   = IDLE;
                    score_l_n = '0;
                    score_r_n = '0;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with short timers and WIN_SCORE = 3.
module tb_score_keeper;

    logic       clk_pix = 1'b0;
    logic       rst_pix_n, frame, start, miss_l, miss_r;
    logic [3:0] score_l, score_r;
    logic       serve, serve_dir, playing, game_over, winner;

    int checks = 0;
    int errors = 0;
    int serve_cnt = 0;
    int serve_ref;

    score_keeper #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (3),
        .POINT_FRAMES (2),
        .OVER_FRAMES  (2)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .frame     (frame),
        .start     (start),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .score_l   (score_l),
        .score_r   (score_r),
        .serve     (serve),
        .serve_dir (serve_dir),
        .playing   (playing),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk_pix = ~clk_pix;

    always @(negedge clk_pix) if (serve === 1'b1) serve_cnt++;

    task automatic clk1();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each frame is a one-cycle pulse followed by one quiet cycle.
    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1; clk1(); frame = 1'b0; clk1();
        end
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_l = l; miss_r = r; clk1(); miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic pulse_start(input logic with_frame);
        start = 1'b1; frame = with_frame; clk1(); start = 1'b0; frame = 1'b0;
    endtask

    initial begin
        rst_pix_n = 1'b0; frame = 1'b0; start = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        clk1(); clk1();
        chk("rst_score_l", score_l, 0);
        chk("rst_score_r", score_r, 0);
        chk("rst_serve", serve, 0);
        chk("rst_serve_dir", serve_dir, 1);
        chk("rst_playing", playing, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        rst_pix_n = 1'b1;
        clk1();

        // First serve: 3 frames after start.
        pulse_start(1'b0);
        chk("serve_wait_playing", playing, 0);
        run_frames(2);
        chk("serve_early", serve_cnt, 0);
        run_frames(1);
        chk("serve1", serve, 1);
        chk("serve1_dir", serve_dir, 1);
        chk("serve1_playing", playing, 1);
        clk1();
        chk("serve1_once", serve_cnt, 1);
        chk("serve1_drop", serve, 0);
        chk("play1_playing", playing, 1);

        // start during PLAY is ignored.
        pulse_start(1'b0);
        chk("start_in_play", playing, 1);

        // Right miss scores left.
        pulse_miss(1'b0, 1'b1);
        chk("pt1_score_l", score_l, 1);
        chk("pt1_score_r", score_r, 0);
        chk("pt1_playing", playing, 0);
        run_frames(2);
        pulse_miss(1'b0, 1'b1);
        chk("miss_in_serve", score_l, 1);
        run_frames(3);
        chk("serve2", serve, 1);
        chk("serve2_dir", serve_dir, 1);
        clk1();

        // Both misses together: nothing happens.
        pulse_miss(1'b1, 1'b1);
        chk("dual_score_l", score_l, 1);
        chk("dual_score_r", score_r, 0);
        chk("dual_playing", playing, 1);

        pulse_miss(1'b1, 1'b0);
        chk("pt2_score_r", score_r, 1);
        chk("pt2_dir", serve_dir, 0);
        run_frames(5);
        chk("serve3", serve, 1);
        chk("serve3_dir", serve_dir, 0);
        clk1();
        pulse_miss(1'b1, 1'b0);
        run_frames(5);
        clk1();
        pulse_miss(1'b1, 1'b0);
        chk("win_score_r", score_r, 3);
        chk("win_score_l", score_l, 1);
        chk("win_game_over", game_over, 1);
        chk("win_winner", winner, 1);
        chk("win_playing", playing, 0);
        pulse_miss(1'b1, 1'b0);
        pulse_miss(1'b0, 1'b1);
        chk("over_frozen_l", score_l, 1);
        chk("over_frozen_r", score_r, 3);

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
        run_frames(2);
        chk("auto_game_over", game_over, 0);
        chk("auto_score_l", score_l, 0);
        chk("auto_score_r", score_r, 0);
        serve_ref = serve_cnt;
        run_frames(4);
        chk("auto_idle_no_serve", serve_cnt, serve_ref);
`else
        run_frames(10);
        chk("hold_game_over", game_over, 1);
        chk("hold_score_r", score_r, 3);
`endif

        // Restart with a coincident frame: the fresh load is not decremented.
        pulse_start(1'b1);
        chk("restart_score_l", score_l, 0);
        chk("restart_score_r", score_r, 0);
        chk("restart_game_over", game_over, 0);
        chk("restart_dir", serve_dir, 1);
        serve_ref = serve_cnt;
        run_frames(2);
        chk("restart_no_early_serve", serve_cnt, serve_ref);
        run_frames(1);
        chk("restart_serve", serve, 1);
        clk1();

        // Reach 2/1 and reset in the middle of POINT.
        pulse_miss(1'b0, 1'b1);
        run_frames(5);
        clk1();
        pulse_miss(1'b0, 1'b1);
        run_frames(5);
        clk1();
        pulse_miss(1'b1, 1'b0);
        chk("pre_rst_score_l", score_l, 2);
        chk("pre_rst_score_r", score_r, 1);
        run_frames(1);
        rst_pix_n = 1'b0; clk1(); rst_pix_n = 1'b1;
        chk("midrst_score_l", score_l, 0);
        chk("midrst_score_r", score_r, 0);
        chk("midrst_playing", playing, 0);
        chk("midrst_dir", serve_dir, 1);
        serve_ref = serve_cnt;
        run_frames(10);
        chk("midrst_no_serve", serve_cnt, serve_ref);
        chk("midrst_idle", playing, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
